// File: rtl/stg3_sub_seq.sv
// Stage-3 subtract address sequencer: walks the source RAM once per start and replays the
// returned coefficient pairs as per-lane write strobes into the subtract block.
module stg3_sub_seq #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned N_POLY_SUB = 2,
   parameter int unsigned RD_LAT     = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_start,
   input  logic [ADDR_WIDTH-1:0]            i_last_addr,
   input  logic                             i_hold,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_rd_en,
   output logic [ADDR_WIDTH-1:0]            o_rd_addr,
   input  logic [N_POLY_SUB*DATA_WIDTH-1:0] i_rd_data,
   output logic [N_POLY_SUB-1:0]            o_we,
   output logic [N_POLY_SUB*ADDR_WIDTH-1:0] o_addr,
   output logic [N_POLY_SUB*DATA_WIDTH-1:0] o_data
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]           last_q, last_d;
   logic                            rd_en;
   logic [RD_LAT-1:0]               vld_q;
   logic [ADDR_WIDTH-1:0]           paddr_q [RD_LAT];
   logic                            we_q;
   logic [ADDR_WIDTH-1:0]           waddr_q;
   logic [N_POLY_SUB*DATA_WIDTH-1:0] wdata_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      rd_en   = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_start) begin
               state_d = StRun;
               cnt_d   = '0;
               last_d  = i_last_addr;
            end
         end
         StRun: begin
            if (!i_hold) begin
               rd_en = 1'b1;
               // Compare before increment so a full-range walk never wraps.
               if (cnt_q == last_q) begin
                  state_d = StDrain;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDrain: begin
            if (vld_q == '0) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= '0;
         vld_q   <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            paddr_q[i] <= '0;
         end
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         vld_q[0]   <= rd_en;
         paddr_q[0] <= cnt_q;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i]   <= vld_q[i-1];
            paddr_q[i] <= paddr_q[i-1];
         end
         // Tail of the pipe lines up with the RAM's returning data.
         we_q <= vld_q[RD_LAT-1];
         if (vld_q[RD_LAT-1]) begin
            waddr_q <= paddr_q[RD_LAT-1];
            wdata_q <= i_rd_data;
         end
      end
   end

   assign o_busy    = (state_q != StIdle);
   assign o_done    = (state_q == StDone);
   assign o_rd_en   = rd_en;
   assign o_rd_addr = cnt_q;
   assign o_we      = {N_POLY_SUB{we_q}};
   assign o_addr    = {N_POLY_SUB{waddr_q}};
   assign o_data    = wdata_q;

endmodule
